ring_slot_stage: RTL and testbench

//  Ring-stop slot stage; sits directly downstream of clockBoundary and consumes its port0_co.
//  Per cycle: ejects a flit addressed to this node, or passes it along the ring.

---
 rtl/ring_slot_stage_pkg.sv | 22 ++
 rtl/ring_inj_fifo.sv | 56 +++++
 rtl/ring_slot_stage.sv | 104 ++++++++++
 tb/tb_ring_slot_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_slot_stage_pkg.sv
// rtl/ring_slot_stage_pkg.sv - flit layout constants and slot action encoding for the ring slot stage
package ring_slot_stage_pkg;

  localparam int FLIT_W       = 128;
  localparam int FLIT_VALID   = 127;
  localparam int FLIT_DST_MSB = 126;
  localparam int FLIT_DST_LSB = 121;
  localparam int DST_W        = FLIT_DST_MSB - FLIT_DST_LSB + 1;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic [1:0] {
    SLOT_EMPTY  = 2'd0,
    SLOT_PASS   = 2'd1,
    SLOT_INJECT = 2'd2
  } slot_action_e;

  function automatic logic [DST_W-1:0] flit_dst(input flit_t f);
    return f[FLIT_DST_MSB:FLIT_DST_LSB];
  endfunction

endpackage

// File: rtl/ring_inj_fifo.sv
// rtl/ring_inj_fifo.sv - local injection FIFO, power-of-2 depth, no write-to-read bypass
module ring_inj_fifo
  import ring_slot_stage_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push_valid,
  input  flit_t push_data,
  output logic  push_ready,
  input  logic  pop,
  output flit_t head,
  output logic  nonempty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  flit_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           full;
  logic           do_push;
  logic           do_pop;

  // Ready depends only on registered occupancy, so a same-cycle pop never frees a full FIFO.
  assign full       = (count == CW'(DEPTH));
  assign push_ready = !full && !rst;
  assign nonempty   = (count != '0);
  assign head       = mem[rd_ptr];
  assign do_push    = push_valid && push_ready;
  assign do_pop     = pop && nonempty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ring_slot_stage.sv
// rtl/ring_slot_stage.sv - ring stop: eject / pass / inject one flit per cycle into a registered slot
// Optional HRING_SLOT_STATS_EN adds saturating deflect and inject counters.
module ring_slot_stage
  import ring_slot_stage_pkg::*;
#(
  parameter int NODE_ID   = 0,
  parameter int INJ_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
`ifdef HRING_SLOT_STATS_EN
  output logic [15:0]  stat_deflect,
  output logic [15:0]  stat_inject,
`endif
  input  logic [127:0] ring_in,
  output logic [127:0] ring_out,
  output logic         eject_valid,
  output logic [127:0] eject_flit,
  input  logic         eject_ready,
  input  logic         inj_valid,
  input  logic [127:0] inj_flit,
  output logic         inj_ready
);

  localparam logic [DST_W-1:0] MY_DST = DST_W'(NODE_ID);

  flit_t        fifo_head;
  logic         fifo_nonempty;
  logic         fifo_pop;
  logic         eject_free;
  logic         in_valid;
  logic         hit;
  logic         capture;
  logic         deflect;
  slot_action_e action;
  flit_t        ring_next;

  ring_inj_fifo #(
    .DEPTH(INJ_DEPTH)
  ) u_inj_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (inj_valid),
    .push_data  (inj_flit),
    .push_ready (inj_ready),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .nonempty   (fifo_nonempty)
  );

  assign eject_free = !eject_valid || eject_ready;
  assign in_valid   = ring_in[FLIT_VALID];
  assign hit        = in_valid && (flit_dst(ring_in) == MY_DST);
  assign capture    = hit && eject_free;
  assign fifo_pop   = (action == SLOT_INJECT);

  // A captured flit frees its slot, so it competes for injection like an empty one.
  always_comb begin
    action    = SLOT_EMPTY;
    ring_next = '0;
    deflect   = 1'b0;
    if (in_valid && !capture) begin
      action    = SLOT_PASS;
      ring_next = ring_in;
      deflect   = hit;
    end else if (fifo_nonempty) begin
      action                = SLOT_INJECT;
      ring_next             = fifo_head;
      ring_next[FLIT_VALID] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ring_out    <= '0;
      eject_valid <= 1'b0;
      eject_flit  <= '0;
    end else begin
      ring_out <= ring_next;
      if (capture) begin
        eject_valid <= 1'b1;
        eject_flit  <= ring_in;
      end else if (eject_ready) begin
        eject_valid <= 1'b0;
      end
    end
  end

`ifdef HRING_SLOT_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_deflect <= '0;
      stat_inject  <= '0;
    end else begin
      if (deflect && stat_deflect != 16'hFFFF)  stat_deflect <= stat_deflect + 16'd1;
      if (fifo_pop && stat_inject != 16'hFFFF)  stat_inject  <= stat_inject + 16'd1;
    end
  end
`else
  logic unused_deflect;
  assign unused_deflect = deflect;
`endif

endmodule

// File: tb/tb_ring_slot_stage.sv
// tb/tb_ring_slot_stage.sv - self-checking bench for ring_slot_stage against a queue-based slot model
module tb_ring_slot_stage;

  localparam int NODE_ID = 0;
  localparam int DEPTH   = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] ring_in;
  logic [127:0] ring_out;
  logic         eject_valid;
  logic [127:0] eject_flit;
  logic         eject_ready;
  logic         inj_valid;
  logic [127:0] inj_flit;
  logic         inj_ready;
`ifdef HRING_SLOT_STATS_EN
  logic [15:0]  stat_deflect;
  logic [15:0]  stat_inject;
`endif

  int total = 0;
  int bad   = 0;

  logic [127:0] q[$];
  logic [127:0] m_ring;
  logic         m_ev;
  logic [127:0] m_ef;
  int           m_defl;
  int           m_inj;
  logic         m_pre_ready;
  logic         pre_ready;

  ring_slot_stage #(.NODE_ID(NODE_ID), .INJ_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef HRING_SLOT_STATS_EN
    .stat_deflect (stat_deflect),
    .stat_inject  (stat_inject),
`endif
    .ring_in      (ring_in),
    .ring_out     (ring_out),
    .eject_valid  (eject_valid),
    .eject_flit   (eject_flit),
    .eject_ready  (eject_ready),
    .inj_valid    (inj_valid),
    .inj_flit     (inj_flit),
    .inj_ready    (inj_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] mk(input logic v, input logic [5:0] dst, input logic [127:0] pl);
    logic [127:0] f;
    f          = pl;
    f[127]     = v;
    f[126:121] = dst;
    return f;
  endfunction

  task automatic model_reset();
    q.delete();
    m_ring = '0;
    m_ev   = 1'b0;
    m_ef   = '0;
    m_defl = 0;
    m_inj  = 0;
  endtask

  // Drives one cycle of inputs and advances the reference model by one ring slot.
  task automatic step(input logic [127:0] ri, input logic iv, input logic [127:0] ifl, input logic er);
    logic         captured;
    logic [127:0] nr;
    logic         free;
    @(negedge clk);
    ring_in     = ri;
    inj_valid   = iv;
    inj_flit    = ifl;
    eject_ready = er;
    #1;
    pre_ready   = inj_ready;
    m_pre_ready = (q.size() < DEPTH);
    free     = !m_ev || er;
    captured = ri[127] && (ri[126:121] == 6'(NODE_ID)) && free;
    nr       = '0;
    if (ri[127] && !captured) begin
      nr = ri;
      if (ri[126:121] == 6'(NODE_ID)) m_defl++;
    end else if (q.size() > 0) begin
      nr      = q.pop_front();
      nr[127] = 1'b1;
      m_inj++;
    end
    if (iv && m_pre_ready) q.push_back(ifl);
    if (captured) begin
      m_ev = 1'b1;
      m_ef = ri;
    end else if (er) begin
      m_ev = 1'b0;
    end
    m_ring = nr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ring_in = '0; inj_valid = 1'b0; inj_flit = '0; eject_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (ring_out !== 128'd0) begin bad++; $display("FAIL reset_ring_out got=%h want=0", ring_out); end
    total++; if (eject_valid !== 1'b0) begin bad++; $display("FAIL reset_eject_valid got=%b want=0", eject_valid); end
    total++; if (eject_flit !== 128'd0) begin bad++; $display("FAIL reset_eject_flit got=%h want=0", eject_flit); end
    total++; if (inj_ready !== 1'b0) begin bad++; $display("FAIL reset_inj_ready got=%b want=0", inj_ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (inj_ready !== 1'b1) begin bad++; $display("FAIL post_reset_inj_ready got=%b want=1", inj_ready); end
  endtask

  task automatic test_pass_through();
    logic [127:0] f;
    f = mk(1'b1, 6'd5, rnd128());
    step(f, 1'b0, '0, 1'b1);
    total++; if (ring_out !== f) begin bad++; $display("FAIL pass_ring_out got=%h want=%h", ring_out, f); end
    total++; if (eject_valid !== 1'b0) begin bad++; $display("FAIL pass_no_eject got=%b want=0", eject_valid); end
  endtask

  task automatic test_eject();
    logic [127:0] f;
    f = mk(1'b1, 6'd0, rnd128());
    step(f, 1'b0, '0, 1'b1);
    total++; if (eject_valid !== 1'b1) begin bad++; $display("FAIL eject_valid got=%b want=1", eject_valid); end
    total++; if (eject_flit !== f) begin bad++; $display("FAIL eject_flit got=%h want=%h", eject_flit, f); end
    total++; if (ring_out !== 128'd0) begin bad++; $display("FAIL eject_ring_out got=%h want=0", ring_out); end
  endtask

  task automatic test_deflect();
    logic [127:0] f0;
    logic [127:0] f1;
    step('0, 1'b0, '0, 1'b1);
    f0 = mk(1'b1, 6'd0, rnd128());
    f1 = mk(1'b1, 6'd0, rnd128());
    step(f0, 1'b0, '0, 1'b0);
    step(f1, 1'b0, '0, 1'b0);
    total++; if (ring_out !== f1) begin bad++; $display("FAIL deflect_ring_out got=%h want=%h", ring_out, f1); end
    total++; if (eject_flit !== f0 || eject_valid !== 1'b1) begin
      bad++; $display("FAIL deflect_eject_hold got=%b/%h want=1/%h", eject_valid, eject_flit, f0);
    end
    step('0, 1'b0, '0, 1'b1);
    total++; if (eject_valid !== 1'b0) begin bad++; $display("FAIL deflect_drain got=%b want=0", eject_valid); end
  endtask

  task automatic test_inject();
    logic [127:0] f;
    logic [127:0] want;
    f        = '0;
    f[7:0]   = 8'hAB;
    want     = f;
    want[127] = 1'b1;
    step('0, 1'b1, f, 1'b1);
    total++; if (ring_out !== 128'd0) begin bad++; $display("FAIL inject_no_bypass got=%h want=0", ring_out); end
    step('0, 1'b0, '0, 1'b1);
    total++; if (ring_out !== want) begin bad++; $display("FAIL inject_ring_out got=%h want=%h", ring_out, want); end
  endtask

  task automatic test_full_fifo();
    logic [127:0] pushed [4];
    logic [127:0] sat;
    logic [127:0] want;
    for (int i = 0; i < 4; i++) begin
      pushed[i] = mk(1'b0, 6'($urandom_range(0, 63)), rnd128());
      sat       = mk(1'b1, 6'd5, rnd128());
      step(sat, 1'b1, pushed[i], 1'b1);
      total++; if (ring_out !== sat) begin bad++; $display("FAIL full_sat_pass[%0d] got=%h want=%h", i, ring_out, sat); end
    end
    total++; if (inj_ready !== 1'b0) begin bad++; $display("FAIL full_inj_ready got=%b want=0", inj_ready); end
    step('0, 1'b1, mk(1'b0, 6'd1, 128'hDEAD), 1'b1);
    total++; if (pre_ready !== 1'b0) begin bad++; $display("FAIL full_ready_during_pop got=%b want=0", pre_ready); end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step('0, 1'b0, '0, 1'b1);
      want      = pushed[i];
      want[127] = 1'b1;
      total++; if (ring_out !== want) begin bad++; $display("FAIL full_drain[%0d] got=%h want=%h", i, ring_out, want); end
    end
    step('0, 1'b0, '0, 1'b1);
    total++; if (ring_out !== 128'd0) begin bad++; $display("FAIL full_drained_empty got=%h want=0", ring_out); end
  endtask

  task automatic test_reset_mid();
    step(mk(1'b1, 6'd0, rnd128()), 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) step(mk(1'b1, 6'd5, rnd128()), 1'b1, rnd128(), 1'b0);
    total++; if (eject_valid !== 1'b1 || q.size() != 3) begin
      bad++; $display("FAIL midrst_setup eject_valid=%b model_fifo=%0d want 1/3", eject_valid, q.size());
    end
    @(negedge clk);
    ring_in = '0; inj_valid = 1'b0; eject_ready = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    total++; if (ring_out !== 128'd0 || eject_valid !== 1'b0 || eject_flit !== 128'd0 || inj_ready !== 1'b0) begin
      bad++; $display("FAIL midrst_outputs ring=%h ev=%b ef=%h ir=%b want all 0", ring_out, eject_valid, eject_flit, inj_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (inj_ready !== 1'b1) begin bad++; $display("FAIL midrst_inj_ready got=%b want=1", inj_ready); end
    step('0, 1'b0, '0, 1'b1);
    total++; if (ring_out !== 128'd0) begin bad++; $display("FAIL midrst_fifo_empty got=%h want=0", ring_out); end
  endtask

  task automatic test_random();
    logic [127:0] ri;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 4))
        0:       ri = '0;
        1:       ri = mk(1'b0, 6'($urandom_range(0, 63)), rnd128());
        2, 3:    ri = mk(1'b1, 6'd0, rnd128());
        default: ri = mk(1'b1, 6'($urandom_range(0, 63)), rnd128());
      endcase
      step(ri, 1'($urandom_range(0, 1)), rnd128(), ($urandom_range(0, 9) < 6));
      total++; if (ring_out !== m_ring) begin bad++; $display("FAIL rand_ring_out[%0d] got=%h want=%h", n, ring_out, m_ring); end
      total++; if (eject_valid !== m_ev) begin bad++; $display("FAIL rand_eject_valid[%0d] got=%b want=%b", n, eject_valid, m_ev); end
      if (m_ev) begin
        total++; if (eject_flit !== m_ef) begin bad++; $display("FAIL rand_eject_flit[%0d] got=%h want=%h", n, eject_flit, m_ef); end
      end
      total++; if (pre_ready !== m_pre_ready) begin bad++; $display("FAIL rand_inj_ready[%0d] got=%b want=%b", n, pre_ready, m_pre_ready); end
    end
`ifdef HRING_SLOT_STATS_EN
    total++; if (stat_deflect !== 16'(m_defl)) begin bad++; $display("FAIL stat_deflect got=%0d want=%0d", stat_deflect, m_defl); end
    total++; if (stat_inject !== 16'(m_inj)) begin bad++; $display("FAIL stat_inject got=%0d want=%0d", stat_inject, m_inj); end
`endif
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_eject();
    test_deflect();
    test_inject();
    test_full_fifo();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
